ibex_mem_responder: RTL and testbench



---
 rtl/ibex_mem_responder.sv | 145 ++++++++++++++
 tb/tb_ibex_mem_responder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_mem_responder.sv
// ibex_mem_responder: simulated memory on the far side of the Ibex
// req/gnt/rvalid bus, answering granted requests in order from a word array.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_i, addr_i       request valid, byte address ([1:0] ignored)
//   we_i, be_i          write enable, byte enables
//   wdata_i             write data, bit 32 is the capability tag
//   gnt_o               request accepted this cycle
//   rvalid_o            response valid (head of the response FIFO)
//   rdata_o             read data plus tag, 0 for writes and errors
//   rdata_intg_o        integrity bits, always 0
//   err_o               response carries a bus error
//   rsp_stall_i         hold responses while high
//   err_inject_i        force an error on the request granted this cycle
//   outstanding_o       response FIFO occupancy
module ibex_mem_responder #(
    parameter int unsigned Depth          = 1024,
    parameter logic [31:0] BaseAddr       = 32'h8000_0000,
    parameter int unsigned GntDelay       = 0,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [32:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [32:0] rdata_o,
    output logic [6:0]  rdata_intg_o,
    output logic        err_o,
    input  logic        rsp_stall_i,
    input  logic        err_inject_i,
    output logic [3:0]  outstanding_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [32:0] Span = 33'(Depth) * 33'd4;
    localparam int unsigned PW =
        (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned FD = 1 << PW;
    localparam logic [PW-1:0] LastPtr = PW'(MaxOutstanding - 1);
    localparam logic [3:0] MaxOcc = 4'(MaxOutstanding);

    logic [32:0]   mem_q [Depth];
    logic [33:0]   fifo_q [FD];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [3:0]    count_q;

    logic          free;
    logic          push;
    logic          pop;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          rsp_err;
    logic [32:0]   rsp_data;
    logic [33:0]   head;

    // Occupancy is the registered value, so a same-cycle pop never frees
    // a slot for this cycle's grant.
    assign free = count_q < MaxOcc;

    if (GntDelay == 0) begin : g_no_delay
        assign gnt_o = req_i & free & ~rst_i;
    end else begin : g_delay
        logic [3:0] cnt_q;

        assign gnt_o = req_i & free & ~rst_i & (cnt_q == 4'(GntDelay));

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (gnt_o || !req_i) begin
                cnt_q <= '0;
            end else if (free) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    // Modulo-2^32 offset: in range exactly when it is below the span.
    assign offset   = addr_i - BaseAddr;
    assign in_range = {1'b0, offset} < Span;
    assign idx      = offset[AW+1:2];

    assign rsp_err  = ~in_range | err_inject_i;
    assign rsp_data = (rsp_err | we_i) ? '0 : mem_q[idx];

    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i && !rsp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
            mem_q[idx][32] <= (be_i == 4'hF) ? wdata_i[32] : 1'b0;
        end
    end

    assign push = gnt_o;
    assign pop  = rvalid_o;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {rsp_err, rsp_data};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head          = fifo_q[rd_ptr_q];
    assign rvalid_o      = (count_q != 4'd0) & ~rsp_stall_i;
    assign rdata_o       = rvalid_o ? head[32:0] : '0;
    assign err_o         = rvalid_o & head[33];
    assign rdata_intg_o  = 7'h00;
    assign outstanding_o = count_q;

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Bench for ibex_mem_responder: directed requests, expected responses
// queued at grant and compared by an independent response monitor.
module tb_ibex_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [32:0] wdata;
    logic        stall;
    logic        inj;
    logic        gnt;
    logic        rvalid;
    logic [32:0] rdata;
    logic [6:0]  intg;
    logic        err;
    logic [3:0]  outst;

    logic        d_req;
    logic        d_gnt;
    logic        d_rvalid;
    logic [32:0] d_rdata;
    logic [6:0]  d_intg;
    logic        d_err;
    logic [3:0]  d_outst;

    int errors = 0;
    int checks = 0;

    typedef logic [33:0] rsp_t;
    rsp_t exp_q[$];
    rsp_t mon_e;

    always #5 clk = ~clk;

    ibex_mem_responder #(
        .GntDelay(0),
        .MaxOutstanding(2)
    ) u_dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_i(req),
        .addr_i(addr),
        .we_i(we),
        .be_i(be),
        .wdata_i(wdata),
        .gnt_o(gnt),
        .rvalid_o(rvalid),
        .rdata_o(rdata),
        .rdata_intg_o(intg),
        .err_o(err),
        .rsp_stall_i(stall),
        .err_inject_i(inj),
        .outstanding_o(outst)
    );

    ibex_mem_responder #(
        .GntDelay(3),
        .MaxOutstanding(2)
    ) u_dly (
        .clk_i(clk),
        .rst_i(rst),
        .req_i(d_req),
        .addr_i(32'h8000_0020),
        .we_i(1'b1),
        .be_i(4'hF),
        .wdata_i(33'h0_1234_5678),
        .gnt_o(d_gnt),
        .rvalid_o(d_rvalid),
        .rdata_o(d_rdata),
        .rdata_intg_o(d_intg),
        .err_o(d_err),
        .rsp_stall_i(1'b0),
        .err_inject_i(1'b0),
        .outstanding_o(d_outst)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rvalid) begin
            if (exp_q.size() == 0) begin
                check("spurious_rvalid", 64'(rvalid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_err", 64'(err), 64'(mon_e[33]));
                check("rsp_rdata", 64'(rdata), 64'(mon_e[32:0]));
                check("rsp_intg", 64'(intg), 64'd0);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [32:0] d,
                         input logic i_inj, input logic e_err,
                         input logic [32:0] e_data);
        bit got;
        got = 0;
        @(posedge clk);
        #1;
        req = 1'b1;
        addr = a;
        we = w;
        be = b;
        wdata = d;
        inj = i_inj;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (gnt) begin
                got = 1;
                exp_q.push_back({e_err, e_data});
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("gnt_seen", 64'(got), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            req = 1'b0;
            inj = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        rst = 1'b1;
        req = 1'b1;
        addr = 32'h8000_0000;
        we = 1'b0;
        be = 4'hF;
        wdata = '0;
        stall = 1'b0;
        inj = 1'b0;
        d_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_outst", 64'(outst), 64'd0);
        check("rst_d_gnt", 64'(d_gnt), 64'd0);
        #1;
        req = 1'b0;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // full write then read with 1-cycle latency
        issue(32'h8000_0010, 1, 4'hF, 33'h1_DEAD_BEEF, 0, 0, 33'h0);
        idle(1);
        issue(32'h8000_0010, 0, 4'hF, 33'h0, 0, 0, 33'h1_DEAD_BEEF);
        check("rvalid_not_at_gnt", 64'(rvalid), 64'd0);
        idle(1);
        @(negedge clk);
        check("read_latency", 64'(rvalid), 64'd1);

        // partial write clears the tag
        issue(32'h8000_0010, 1, 4'b0010, 33'h0_0000_5500, 0, 0, 33'h0);
        issue(32'h8000_0010, 0, 4'hF, 33'h0, 0, 0, 33'h0_DEAD_55EF);

        // errors: below range, injected read, injected write
        issue(32'h7FFF_FFFC, 0, 4'hF, 33'h0, 0, 1, 33'h0);
        issue(32'h8000_0010, 0, 4'hF, 33'h0, 1, 1, 33'h0);
        issue(32'h8000_0010, 1, 4'hF, 33'h1_0000_0000, 1, 1, 33'h0);
        issue(32'h8000_0010, 0, 4'hF, 33'h0, 0, 0, 33'h0_DEAD_55EF);

        // top word in range, one past the end is an error
        issue(32'h8000_0FFC, 1, 4'hF, 33'h1_CAFE_F00D, 0, 0, 33'h0);
        issue(32'h8000_0FFC, 0, 4'hF, 33'h0, 0, 0, 33'h1_CAFE_F00D);
        issue(32'h8000_1000, 0, 4'hF, 33'h0, 0, 1, 33'h0);

        // preload for the stall test, back to back
        issue(32'h8000_0000, 1, 4'hF, 33'h0_1111_1111, 0, 0, 33'h0);
        issue(32'h8000_0004, 1, 4'hF, 33'h1_2222_2222, 0, 0, 33'h0);
        issue(32'h8000_0008, 1, 4'hF, 33'h0_3333_3333, 0, 0, 33'h0);
        idle(3);

        // stall with two slots: third request waits
        @(posedge clk);
        #1;
        stall = 1'b1;
        req = 1'b1;
        we = 1'b0;
        be = 4'hF;
        addr = 32'h8000_0000;
        @(negedge clk);
        check("stall_gnt_a", 64'(gnt), 64'd1);
        if (gnt) exp_q.push_back({1'b0, 33'h0_1111_1111});
        @(posedge clk);
        #1;
        addr = 32'h8000_0004;
        @(negedge clk);
        check("stall_gnt_b", 64'(gnt), 64'd1);
        if (gnt) exp_q.push_back({1'b0, 33'h1_2222_2222});
        @(posedge clk);
        #1;
        addr = 32'h8000_0008;
        @(negedge clk);
        check("full_gnt", 64'(gnt), 64'd0);
        check("full_outst", 64'(outst), 64'd2);
        check("stalled_rvalid", 64'(rvalid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("full_gnt_hold", 64'(gnt), 64'd0);
        @(posedge clk);
        #1;
        stall = 1'b0;
        @(negedge clk);
        check("full_pop_no_gnt", 64'(gnt), 64'd0);
        check("release_rvalid_a", 64'(rvalid), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("third_gnt", 64'(gnt), 64'd1);
        check("release_rvalid_b", 64'(rvalid), 64'd1);
        check("pushpop_outst", 64'(outst), 64'd1);
        if (gnt) exp_q.push_back({1'b0, 33'h0_3333_3333});
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check("release_rvalid_c", 64'(rvalid), 64'd1);
        idle(2);
        @(negedge clk);
        check("drained_outst", 64'(outst), 64'd0);
        check("drained_queue", 64'(exp_q.size()), 64'd0);

        // reset with two outstanding responses
        @(posedge clk);
        #1;
        stall = 1'b1;
        req = 1'b1;
        addr = 32'h8000_0000;
        @(negedge clk);
        if (gnt) exp_q.push_back({1'b0, 33'h0_1111_1111});
        @(posedge clk);
        #1;
        addr = 32'h8000_0004;
        @(negedge clk);
        if (gnt) exp_q.push_back({1'b0, 33'h1_2222_2222});
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check("pre_rst_outst", 64'(outst), 64'd2);
        #1;
        rst = 1'b1;
        stall = 1'b0;
        #1;
        check("async_rst_outst", 64'(outst), 64'd0);
        check("async_rst_rvalid", 64'(rvalid), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (rvalid) stale++;
        end
        check("stale_rsp", 64'(stale), 64'd0);

        // grant delay of 3: held request
        @(posedge clk);
        #1;
        d_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("dly_held", 64'(d_gnt), 64'(k == 4));
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
        @(negedge clk);
        check("dly_rvalid", 64'(d_rvalid), 64'd1);
        check("dly_rdata", 64'(d_rdata), 64'd0);
        check("dly_err", 64'(d_err), 64'd0);
        check("dly_intg", 64'(d_intg), 64'd0);
        check("dly_outst", 64'(d_outst), 64'd1);

        // dropped after 2 cycles restarts the count
        @(posedge clk);
        #1;
        d_req = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("dly_short", 64'(d_gnt), 64'd0);
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
        @(negedge clk);
        check("dly_dropped", 64'(d_gnt), 64'd0);
        @(posedge clk);
        #1;
        d_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("dly_restart", 64'(d_gnt), 64'(k == 4));
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
